// File: rtl/gpio_in_capture.sv
// rtl/gpio_in_capture.sv - synchronised, debounced GPIO input capture with edge flags, event counter and irq
module gpio_in_capture #(
  parameter int WIDTH     = 8,
  parameter int DEBOUNCE  = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [2:0]       reg_sel_i,
  input  logic             we_i,
  input  logic [31:0]      di_i,
  output logic [31:0]      do_o,
  input  logic [WIDTH-1:0] pins_i,
  output logic             irq_o
);

  // Debounce counter only needs to reach DEBOUNCE-1; the flip happens on the next differing edge.
  localparam int DBW = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE);
  localparam logic [DBW-1:0]       DB_LAST = DBW'(DEBOUNCE - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [2:0] SEL_IN   = 3'd0;
  localparam logic [2:0] SEL_RISE = 3'd1;
  localparam logic [2:0] SEL_FALL = 3'd2;
  localparam logic [2:0] SEL_STAT = 3'd3;
  localparam logic [2:0] SEL_CNT  = 3'd4;

  logic [WIDTH-1:0]     sync1_q, sync2_q;
  logic [WIDTH-1:0]     level_q, level_d;
  logic [DBW-1:0]       dbc_q [WIDTH];
  logic [DBW-1:0]       dbc_d [WIDTH];
  logic [WIDTH-1:0]     rise_q, rise_d;
  logic [WIDTH-1:0]     fall_q, fall_d;
  logic [WIDTH-1:0]     stat_q, stat_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]     edge_ev;
  logic [WIDTH-1:0]     w1c_mask;

  always_comb begin
    level_d = level_q;
    for (int i = 0; i < WIDTH; i++) begin
      dbc_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (dbc_q[i] == DB_LAST) begin
          level_d[i] = ~level_q[i];
        end else begin
          dbc_d[i] = dbc_q[i] + DBW'(1);
        end
      end
    end
  end

  // Edge enables are the registered values, so a write only affects later edges.
  always_comb begin
    edge_ev  = (level_d & ~level_q & rise_q) | (~level_d & level_q & fall_q);
    w1c_mask = (we_i && reg_sel_i == SEL_STAT) ? di_i[WIDTH-1:0] : '0;
    stat_d   = (stat_q & ~w1c_mask) | edge_ev;
    rise_d   = (we_i && reg_sel_i == SEL_RISE) ? di_i[WIDTH-1:0] : rise_q;
    fall_d   = (we_i && reg_sel_i == SEL_FALL) ? di_i[WIDTH-1:0] : fall_q;
    cnt_d    = cnt_q;
    if (we_i && reg_sel_i == SEL_CNT) begin
      cnt_d = (|edge_ev) ? CNT_WIDTH'(1) : '0;
    end else if ((|edge_ev) && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      stat_q  <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < WIDTH; i++) dbc_q[i] <= '0;
    end else begin
      sync1_q <= pins_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      stat_q  <= stat_d;
      cnt_q   <= cnt_d;
      for (int i = 0; i < WIDTH; i++) dbc_q[i] <= dbc_d[i];
    end
  end

  always_comb begin
    do_o = '0;
    case (reg_sel_i)
      SEL_IN:   do_o[WIDTH-1:0]     = level_q;
      SEL_RISE: do_o[WIDTH-1:0]     = rise_q;
      SEL_FALL: do_o[WIDTH-1:0]     = fall_q;
      SEL_STAT: do_o[WIDTH-1:0]     = stat_q;
      SEL_CNT:  do_o[CNT_WIDTH-1:0] = cnt_q;
      default:  do_o = '0;
    endcase
  end

  assign irq_o = |stat_q;

endmodule

// File: tb/tb_gpio_in_capture.sv
// tb/tb_gpio_in_capture.sv - directed self-checking bench for gpio_in_capture
module tb_gpio_in_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  sel;
  logic        we;
  logic [31:0] di;
  logic [31:0] rdata;
  logic [7:0]  pins;
  logic        irq;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  gpio_in_capture #(.WIDTH(8), .DEBOUNCE(4), .CNT_WIDTH(2)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .reg_sel_i (sel),
    .we_i      (we),
    .di_i      (di),
    .do_o      (rdata),
    .pins_i    (pins),
    .irq_o     (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    sel = a;
    di  = d;
    we  = 1'b1;
    step(1);
    we  = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    sel = a;
    #1;
    chk(tag, rdata, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    we    = 1'b0;
    sel   = 3'd0;
    di    = '0;
    pins  = 8'hFF;
    step(2);

    // reset state
    for (int i = 0; i < 8; i++) rd_chk("reset_rd", 3'(i), 32'h0);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rst_n = 1'b1;
    step(5);
    rd_chk("rel_in_e5", 3'd0, 32'h00);
    step(1);
    rd_chk("rel_in_e6", 3'd0, 32'hFF);
    rd_chk("rel_stat", 3'd3, 32'h00);

    // rising edge on pin0
    wr(3'd1, 32'h01);
    pins = 8'hFE;
    step(8);
    rd_chk("r_low_in", 3'd0, 32'hFE);
    rd_chk("r_low_stat", 3'd3, 32'h00);
    pins = 8'hFF;
    step(5);
    rd_chk("r_e5_in", 3'd0, 32'hFE);
    rd_chk("r_e5_stat", 3'd3, 32'h00);
    step(1);
    rd_chk("r_e6_in", 3'd0, 32'hFF);
    rd_chk("r_e6_stat", 3'd3, 32'h01);
    chk("r_e6_irq", {31'd0, irq}, 32'd1);
    rd_chk("r_e6_cnt", 3'd4, 32'd1);
    step(4);

    // glitch rejection
    wr(3'd1, 32'hFF);
    wr(3'd2, 32'hFF);
    rd_chk("rise_rb", 3'd1, 32'hFF);
    rd_chk("fall_rb", 3'd2, 32'hFF);
    pins = 8'hFD;
    step(3);
    pins = 8'hFF;
    step(10);
    rd_chk("g_in", 3'd0, 32'hFF);
    rd_chk("g_stat", 3'd3, 32'h01);
    rd_chk("g_cnt", 3'd4, 32'd1);

    // W1C vs set race on pin1
    pins = 8'hFD;
    step(8);
    rd_chk("f_stat", 3'd3, 32'h03);
    rd_chk("f_cnt", 3'd4, 32'd2);
    wr(3'd3, 32'h02);
    rd_chk("w1c_stat", 3'd3, 32'h01);
    pins = 8'hFF;
    step(5);
    rd_chk("race_pre_in", 3'd0, 32'hFD);
    wr(3'd3, 32'h03);
    rd_chk("race_stat", 3'd3, 32'h02);
    chk("race_irq", {31'd0, irq}, 32'd1);
    rd_chk("race_cnt", 3'd4, 32'd3);
    rd_chk("race_in", 3'd0, 32'hFF);

    // counter saturation
    wr(3'd4, 32'h0);
    rd_chk("cnt_clr", 3'd4, 32'd0);
    for (int k = 0; k < 5; k++) begin
      pins = (k % 2 == 0) ? 8'hF7 : 8'hFF;
      step(8);
      rd_chk("cnt_sat", 3'd4, (k < 3) ? 32'(k + 1) : 32'd3);
    end
    rd_chk("unmapped", 3'd5, 32'h0);
    wr(3'd4, 32'h0);
    rd_chk("cnt_clr2", 3'd4, 32'd0);
    pins = 8'hFF;
    step(5);
    wr(3'd4, 32'h5);
    rd_chk("cnt_wr_ev", 3'd4, 32'd1);

    // reset mid-debounce
    pins = 8'hFB;
    step(8);
    wr(3'd3, 32'hFF);
    rd_chk("pre6_stat", 3'd3, 32'h00);
    chk("pre6_irq", {31'd0, irq}, 32'd0);
    pins = 8'hFF;
    step(3);
    rst_n = 1'b0;
    rd_chk("mid_rst_in", 3'd0, 32'h00);
    rd_chk("mid_rst_stat", 3'd3, 32'h00);
    step(1);
    rst_n = 1'b1;
    step(5);
    rd_chk("r6_e5_in", 3'd0, 32'h00);
    step(1);
    rd_chk("r6_e6_in", 3'd0, 32'hFF);
    rd_chk("r6_stat", 3'd3, 32'h00);
    chk("r6_irq", {31'd0, irq}, 32'd0);
    rd_chk("r6_cnt", 3'd4, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
